// File: rtl/rf_sync_read.sv
`default_nettype none
// ============================================================================
//  Module      : rf_sync_read
//  Description : DEPTH x WIDTH register file with one write port and two
//                synchronous read ports sharing a single read request.
//                Read data is registered: it appears one cycle after the
//                request edge, qualified by rd_valid.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   1      single clock, rising edge
//    rst        in   1      synchronous active-high reset (clears everything)
//    wr_en      in   1      write strobe
//    wr_addr    in   AW     write register index
//    wr_data    in   WIDTH  write data
//    rd_en      in   1      read request for both read ports
//    rd_a_addr  in   AW     read port A index
//    rd_b_addr  in   AW     read port B index
//    rd_a_data  out  WIDTH  registered read data, port A
//    rd_b_data  out  WIDTH  registered read data, port B
//    rd_valid   out  1      high for the cycle after an accepted read
//
//  Build option
//    RF_WR_BYPASS_EN : when defined, a read whose address matches a write at
//                      the same edge returns the incoming write data
//                      (per port). When undefined, it returns the value
//                      stored before that write.
// ============================================================================
module rf_sync_read #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_a_addr,
  input  logic [AW-1:0]    rd_b_addr,
  output logic [WIDTH-1:0] rd_a_data,
  output logic [WIDTH-1:0] rd_b_data,
  output logic             rd_valid
);

  localparam logic [WIDTH-1:0] c_ZERO = '0;

  // Address width must exactly cover the register count, otherwise some
  // indices would alias or fall outside the array.
  generate
    if ((DEPTH < 2) || (DEPTH != (1 << AW))) begin : g_bad_param
      $error("rf_sync_read: DEPTH must be a power of two >= 2 and equal 2**AW");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_a;
  logic [WIDTH-1:0] r_rd_b;
  logic             r_rd_valid;

  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  // --------------------------------------------------------------------------
  // Storage: only the write path updates an entry; reset clears all entries
  // and takes priority over a coincident write.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= c_ZERO;
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Read-data selection. The array is read before this edge's write lands,
  // so without the bypass a same-address read sees the old contents.
  // --------------------------------------------------------------------------
`ifdef RF_WR_BYPASS_EN
  logic w_hit_a;
  logic w_hit_b;

  assign w_hit_a = wr_en && (wr_addr == rd_a_addr);
  assign w_hit_b = wr_en && (wr_addr == rd_b_addr);
  assign w_rd_a  = w_hit_a ? wr_data : r_mem[rd_a_addr];
  assign w_rd_b  = w_hit_b ? wr_data : r_mem[rd_b_addr];
`else
  assign w_rd_a  = r_mem[rd_a_addr];
  assign w_rd_b  = r_mem[rd_b_addr];
`endif

  // --------------------------------------------------------------------------
  // Single read pipeline stage. Data registers hold when no read is
  // requested; rd_valid tracks the request one cycle late.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_a     <= c_ZERO;
      r_rd_b     <= c_ZERO;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_a <= w_rd_a;
        r_rd_b <= w_rd_b;
      end
    end
  end

  assign rd_a_data = r_rd_a;
  assign rd_b_data = r_rd_b;
  assign rd_valid  = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_rf_sync_read.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_sync_read
//  Description : Directed self-checking bench for rf_sync_read (default
//                parameters). Expected values are hand-computed constants;
//                the same-edge write/read expectation follows the
//                RF_WR_BYPASS_EN build option.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_sync_read;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_a_addr;
  logic [AW-1:0]    rd_b_addr;
  logic [WIDTH-1:0] rd_a_data;
  logic [WIDTH-1:0] rd_b_data;
  logic             rd_valid;

  int n_tests;
  int n_fail;

  rf_sync_read #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_a_addr (rd_a_addr),
    .rd_b_addr (rd_b_addr),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .rd_valid  (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_a_addr = '0; rd_b_addr = '0;
  endtask

  task automatic write1(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  logic [WIDTH-1:0] exp_a6;
  logic [WIDTH-1:0] exp_same;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("reset_valid", {15'd0, rd_valid}, 16'h0000);
    chk("reset_a", rd_a_data, 16'h0000);
    chk("reset_b", rd_b_data, 16'h0000);

    // First read after reset returns zeros
    rd_en = 1'b1; rd_a_addr = 3'd3; rd_b_addr = 3'd5;
    tick();
    rd_en = 1'b0;
    chk("rd0_a", rd_a_data, 16'h0000);
    chk("rd0_b", rd_b_data, 16'h0000);
    chk("rd0_valid", {15'd0, rd_valid}, 16'h0001);
    tick();
    chk("rd0_valid_drop", {15'd0, rd_valid}, 16'h0000);

    // Write then read next cycle
    write1(3'd2, 16'hBEEF);
    rd_en = 1'b1; rd_a_addr = 3'd2; rd_b_addr = 3'd3;
    tick();
    rd_en = 1'b0;
    chk("wr_rd_a", rd_a_data, 16'hBEEF);
    chk("wr_rd_b", rd_b_data, 16'h0000);
    chk("wr_rd_valid", {15'd0, rd_valid}, 16'h0001);

    // Same-edge write and read of the same address
    write1(3'd4, 16'h00AA);
`ifdef RF_WR_BYPASS_EN
    exp_same = 16'h1234;
    exp_a6   = 16'h6666;
`else
    exp_same = 16'h00AA;
    exp_a6   = 16'h0000;
`endif
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h1234;
    rd_en = 1'b1; rd_a_addr = 3'd4; rd_b_addr = 3'd4;
    tick();
    wr_en = 1'b0;
    chk("coll_a", rd_a_data, exp_same);
    chk("coll_b", rd_b_data, exp_same);
    rd_en = 1'b1; rd_a_addr = 3'd4; rd_b_addr = 3'd4;
    tick();
    rd_en = 1'b0;
    chk("coll_next_a", rd_a_data, 16'h1234);
    chk("coll_next_b", rd_b_data, 16'h1234);

    // Per-port collision: only port A matches the write address
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h6666;
    rd_en = 1'b1; rd_a_addr = 3'd6; rd_b_addr = 3'd2;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("port_a_coll", rd_a_data, exp_a6);
    chk("port_b_nocoll", rd_b_data, 16'hBEEF);

    // Hold with rd_en=0 while reg 1 is rewritten
    write1(3'd1, 16'h1111);
    rd_en = 1'b1; rd_a_addr = 3'd1; rd_b_addr = 3'd2;
    tick();
    rd_en = 1'b0;
    chk("hold_pre_a", rd_a_data, 16'h1111);
    chk("hold_pre_b", rd_b_data, 16'hBEEF);
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h9990 + 16'(k);
      tick();
      chk("hold_a", rd_a_data, 16'h1111);
      chk("hold_b", rd_b_data, 16'hBEEF);
      chk("hold_valid", {15'd0, rd_valid}, 16'h0000);
    end
    wr_en = 1'b0;
    rd_en = 1'b1; rd_a_addr = 3'd1; rd_b_addr = 3'd1;
    tick();
    rd_en = 1'b0;
    chk("rewrite_a", rd_a_data, 16'h9992);
    chk("rewrite_b", rd_b_data, 16'h9992);

    // Reset dominates a coincident write and read
    write1(3'd7, 16'h5555);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF;
    rd_en = 1'b1; rd_a_addr = 3'd7; rd_b_addr = 3'd2;
    tick();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("rstdom_valid", {15'd0, rd_valid}, 16'h0000);
    chk("rstdom_a", rd_a_data, 16'h0000);
    chk("rstdom_b", rd_b_data, 16'h0000);
    rd_en = 1'b1; rd_a_addr = 3'd7; rd_b_addr = 3'd2;
    tick();
    rd_en = 1'b0;
    chk("post_rst_a", rd_a_data, 16'h0000);
    chk("post_rst_b", rd_b_data, 16'h0000);
    chk("post_rst_valid", {15'd0, rd_valid}, 16'h0001);

    // Back-to-back writes then back-to-back reads
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 16'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1; rd_a_addr = AW'(i); rd_b_addr = AW'(7 - i);
      tick();
      chk("b2b_a", rd_a_data, 16'(i + 1));
      chk("b2b_b", rd_b_data, 16'(8 - i));
      chk("b2b_valid", {15'd0, rd_valid}, 16'h0001);
    end
    rd_en = 1'b0;
    tick();
    chk("b2b_end_valid", {15'd0, rd_valid}, 16'h0000);
    chk("b2b_end_hold_a", rd_a_data, 16'h0008);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_sync_read.md
RF_SYNC_READ -- requirements
Module: rf_sync_read

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data bits per register.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of registers; power of two, minimum 2.
REQ-003 The block SHALL have parameter AW, default 3, address width, equal to log2(DEPTH).
REQ-004 Port clk, input, 1, single clock; all state SHALL update on its rising edge only.
REQ-005 Port rst, input, 1, reset, synchronous and active-high.
REQ-006 Port wr_en, input, 1, write strobe.
REQ-007 Port wr_addr, input, AW, write register index.
REQ-008 Port wr_data, input, WIDTH, write data.
REQ-009 Port rd_en, input, 1, read request, both read ports.
REQ-010 Port rd_a_addr, input, AW, read port A index.
REQ-011 Port rd_b_addr, input, AW, read port B index.
REQ-012 Port rd_a_data, output, WIDTH, registered read data, port A.
REQ-013 Port rd_b_data, output, WIDTH, registered read data, port B.
REQ-014 Port rd_valid, output, 1, high for exactly the cycle after an accepted read.

Function
REQ-015 Storage SHALL be DEPTH x WIDTH registers, each updated only on the write path.
REQ-016 Write: at clk edge with wr_en=1 and rst=0, mem[wr_addr] SHALL take wr_data; all other entries SHALL hold.
REQ-017 Write with wr_en=0 SHALL leave storage unchanged.
REQ-018 Read: at clk edge with rd_en=1 and rst=0, rd_a_data/rd_b_data SHALL load the selected entries; latency is 1 cycle from the request edge.
REQ-019 rd_valid SHALL be 1 in the cycle after an edge with rd_en=1 and rst=0; otherwise 0.
REQ-020 With rd_en=0, rd_a_data and rd_b_data SHALL hold their last values.
REQ-021 Back-to-back reads SHALL be accepted every cycle with no bubbles.
REQ-022 Both ports reading the same address SHALL return identical data.
REQ-023 A read of an address not written in the same cycle SHALL return the stored value, independent of any concurrent write.
REQ-024 A same-cycle write and read of the same address SHALL follow REQ-032/REQ-033.
REQ-025 A write in cycle N SHALL be visible to any read issued in cycle N+1 or later.
REQ-026 The block SHALL have no other state machine; the read pipeline is a single register stage.

Reset
REQ-027 rst=1 at a clk edge SHALL clear all DEPTH storage entries to 0.
REQ-028 rst=1 SHALL clear rd_a_data, rd_b_data and rd_valid to 0.
REQ-029 rst SHALL dominate wr_en and rd_en; a write or read in a reset cycle SHALL be discarded.
REQ-030 Reset asserted mid-stream SHALL drop the in-flight read: rd_valid=0 in the next cycle.
REQ-031 The first accepted read after reset deasserts SHALL return 0 for any unwritten entry.

Configuration
REQ-032 With RF_WR_BYPASS_EN defined: a read with rd_X_addr == wr_addr and wr_en=1 at the same edge SHALL return wr_data on that port, per port independently.
REQ-033 With RF_WR_BYPASS_EN undefined: such a read SHALL return the pre-write stored value; the new value SHALL be visible from the next read onward.

Verification
REQ-034 Reset, then rd_en=1 with A=3, B=5 -> next cycle rd_a_data=0, rd_b_data=0, rd_valid=1.
REQ-035 Write 0xBEEF to reg 2, next cycle rd_en with A=2 -> following cycle rd_a_data=0xBEEF, rd_valid=1.
REQ-036 Same edge: wr_en=1, wr_addr=4, wr_data=0x1234, rd_en=1, A=4, B=4; reg 4 previously 0x00AA -> both ports 0x1234 with RF_WR_BYPASS_EN defined, 0x00AA without; the next read of reg 4 returns 0x1234 in both builds.
REQ-037 Read A=1, B=2, then rd_en=0 for 3 cycles while reg 1 is rewritten -> outputs hold their old values and rd_valid=0 in those cycles.
REQ-038 Write 0x5555 to reg 7, assert rst together with a write of 0xFFFF to reg 7 and rd_en=1 -> next cycle rd_valid=0 and outputs 0; a subsequent read of reg 7 returns 0.
REQ-039 Write 0x0001..0x0008 to regs 0..7 on consecutive cycles, then read A=i, B=7-i for i=0..7 on consecutive cycles -> each result appears one cycle later with rd_valid continuously high.
